// File: rtl/ika87ad_irq_ctrl.sv
// Interrupt priority controller for the IKA87AD core: latches request pulses,
// gates them with mask/IE, and presents the winning vector to the sequencer.
module ika87ad_irq_ctrl #(
  parameter int NSRC = 11
) (
  input  logic            i_EMUCLK,
  input  logic            i_MRST_n,
  input  logic [NSRC-1:0] i_IRQ_PULSE,
  input  logic [NSRC-1:1] i_MASK,
  input  logic            i_EI_STB,
  input  logic            i_DI_STB,
  input  logic            i_IRQ_ACK,
  input  logic            i_SKIT_STB,
  input  logic [3:0]      i_SKIT_CODE,
  output logic            o_IRQ_REQ,
  output logic [15:0]     o_VECTOR,
  output logic [3:0]      o_IRQ_CODE,
  output logic            o_SKIT_HIT,
  output logic            o_IE,
  output logic [NSRC-1:0] o_FLAGS
);

  typedef enum logic [1:0] {IDLE, PEND, ACKD} state_t;

  state_t            state, state_next;
  logic [NSRC-1:0]   flags, flags_next;
  logic              ie, ie_next;
  logic              req_next, skit_hit_next;
  logic [15:0]       vector_next;
  logic [3:0]        code_next;

  logic [NSRC-1:0]   elig, multi, ack_clr, skit_clr, clr;
  logic [3:0]        sel;
  logic              any_elig, ack_take, skit_valid;

  // Group g (1..5) owns sources 2g-1 and 2g; vector is g*8, NMI sits at 4.
  function automatic logic [15:0] vec_of(input logic [3:0] code);
    logic [3:0] grp;
    grp = (code + 4'd1) >> 1;
    if (code == 4'd0) return 16'h0004;
    return {9'd0, grp, 3'b000};
  endfunction

  // NMI bypasses both mask and IE.
  assign elig     = flags & {~i_MASK & {(NSRC-1){ie}}, 1'b1};
  assign any_elig = |elig;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) sel = 4'(i);
    end
  end

  always_comb begin
    multi = '0;
    for (int g = 1; 2 * g < NSRC; g++) begin
      multi[2*g-1] = ~i_MASK[2*g-1] & ~i_MASK[2*g];
      multi[2*g]   = ~i_MASK[2*g-1] & ~i_MASK[2*g];
    end
  end

  // A shared-vector group with both members live leaves flag clearing to SKIT.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (o_IRQ_CODE == 4'(i) && !multi[i]) ack_clr[i] = 1'b1;
    end
  end

  assign skit_valid = i_SKIT_STB && (i_SKIT_CODE != 4'd0) && (i_SKIT_CODE <= 4'(NSRC - 1));

  always_comb begin
    skit_clr = '0;
    for (int i = 1; i < NSRC; i++) begin
      if (skit_valid && i_SKIT_CODE == 4'(i)) skit_clr[i] = 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    req_next    = o_IRQ_REQ;
    vector_next = o_VECTOR;
    code_next   = o_IRQ_CODE;
    ack_take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_elig) begin
          state_next  = PEND;
          req_next    = 1'b1;
          vector_next = vec_of(sel);
          code_next   = sel;
        end
      end
      PEND: begin
        if (i_IRQ_ACK) begin
          ack_take   = 1'b1;
          state_next = ACKD;
          req_next   = 1'b0;
        end else if (!any_elig) begin
          state_next = IDLE;
          req_next   = 1'b0;
        end else begin
          vector_next = vec_of(sel);
          code_next   = sel;
        end
      end
      ACKD:    state_next = IDLE;
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  // Sets are applied after clears so a same-cycle pulse always survives.
  always_comb begin
    clr        = skit_clr | (ack_take ? ack_clr : '0);
    flags_next = (flags & ~clr) | i_IRQ_PULSE;

    ie_next = ie;
    if (ack_take || i_DI_STB) ie_next = 1'b0;
    else if (i_EI_STB)        ie_next = 1'b1;

    skit_hit_next = o_SKIT_HIT;
    if (i_SKIT_STB) skit_hit_next = |(flags & skit_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state      <= IDLE;
      flags      <= '0;
      ie         <= 1'b0;
      o_IRQ_REQ  <= 1'b0;
      o_VECTOR   <= 16'h0000;
      o_IRQ_CODE <= 4'd0;
      o_SKIT_HIT <= 1'b0;
    end else begin
      state      <= state_next;
      flags      <= flags_next;
      ie         <= ie_next;
      o_IRQ_REQ  <= req_next;
      o_VECTOR   <= vector_next;
      o_IRQ_CODE <= code_next;
      o_SKIT_HIT <= skit_hit_next;
    end
  end

  assign o_IE    = ie;
  assign o_FLAGS = flags;

endmodule

// File: tb/tb_ika87ad_irq_ctrl.sv
// Directed scoreboard bench for ika87ad_irq_ctrl: expected values are queued
// as stimulus is applied and compared on the falling edge after the response.
module tb_ika87ad_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] irq_pulse;
  logic [10:1] mask;
  logic        ei_stb, di_stb, irq_ack, skit_stb;
  logic [3:0]  skit_code;
  logic        irq_req, skit_hit, ie;
  logic [15:0] vector;
  logic [3:0]  irq_code;
  logic [10:0] flags;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  ika87ad_irq_ctrl dut (
    .i_EMUCLK   (clk),
    .i_MRST_n   (rst_n),
    .i_IRQ_PULSE(irq_pulse),
    .i_MASK     (mask),
    .i_EI_STB   (ei_stb),
    .i_DI_STB   (di_stb),
    .i_IRQ_ACK  (irq_ack),
    .i_SKIT_STB (skit_stb),
    .i_SKIT_CODE(skit_code),
    .o_IRQ_REQ  (irq_req),
    .o_VECTOR   (vector),
    .o_IRQ_CODE (irq_code),
    .o_SKIT_HIT (skit_hit),
    .o_IE       (ie),
    .o_FLAGS    (flags)
  );

  task automatic push(input logic [31:0] e);
    sb_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input int idx);
    irq_pulse[idx] = 1'b1;
    tick();
    irq_pulse = '0;
  endtask

  task automatic skit(input logic [3:0] code);
    skit_code = code;
    skit_stb  = 1'b1;
    tick();
    skit_stb  = 1'b0;
  endtask

  task automatic strobe_ei();
    ei_stb = 1'b1;
    tick();
    ei_stb = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_pulse = '0; mask = '0; ei_stb = 0; di_stb = 0;
    irq_ack = 0; skit_stb = 0; skit_code = '0;

    // Reset state
    push(0); push(0); push(0); push(0); push(0); push(0);
    tick(); tick();
    check("rst_req", 32'(irq_req));   check("rst_vector", 32'(vector));
    check("rst_code", 32'(irq_code)); check("rst_hit", 32'(skit_hit));
    check("rst_ie", 32'(ie));         check("rst_flags", 32'(flags));
    rst_n = 1'b1;

    // Multi group {3,4}: ACK leaves flag, SKIT clears it; EI with ACK loses
    strobe_ei();
    push(32'h008); push(0);
    pulse(3);
    check("t1_flag_latency", 32'(flags)); check("t1_req_latency", 32'(irq_req));
    push(1); push(32'h0010); push(3);
    tick();
    check("t1_req", 32'(irq_req)); check("t1_vector", 32'(vector)); check("t1_code", 32'(irq_code));
    push(0); push(0); push(32'h008); push(32'h0010);
    ei_stb = 1'b1; ack(); ei_stb = 1'b0;
    check("t1_ack_req", 32'(irq_req)); check("t1_ack_ie", 32'(ie));
    check("t1_multi_keep", 32'(flags)); check("t1_vec_frozen", 32'(vector));
    push(1); push(0);
    skit(4'd3);
    check("t1_skit_hit", 32'(skit_hit)); check("t1_skit_clr", 32'(flags));

    // Masked partner: auto-clear on ACK, no REQ until EI
    mask[4] = 1'b1;
    strobe_ei();
    pulse(3);
    push(1); push(3);
    tick();
    check("t2_req", 32'(irq_req)); check("t2_code", 32'(irq_code));
    push(0); push(0); push(0);
    ack();
    check("t2_autoclr", 32'(flags)); check("t2_ie", 32'(ie)); check("t2_req_drop", 32'(irq_req));
    push(0);
    tick();
    check("t2_dead_cycle", 32'(irq_req));
    pulse(3);
    push(0); push(32'h008);
    tick();
    check("t2_no_req_ie0", 32'(irq_req)); check("t2_flag_held", 32'(flags));
    strobe_ei();
    push(1);
    tick();
    check("t2_req_after_ei", 32'(irq_req));
    ack(); tick();
    mask = '0;

    // NMI ignores IE; masked-out source stays latched
    pulse(8);
    push(0); push(32'h100);
    tick();
    check("t3_no_req", 32'(irq_req)); check("t3_flag8", 32'(flags));
    pulse(0);
    push(1); push(32'h0004); push(0);
    tick();
    check("t3_nmi_req", 32'(irq_req)); check("t3_nmi_vec", 32'(vector)); check("t3_nmi_code", 32'(irq_code));
    push(32'h100);
    ack();
    check("t3_nmi_clr", 32'(flags));
    tick();
    push(1); push(0);
    skit(4'd8);
    check("t3_skit8_hit", 32'(skit_hit)); check("t3_skit8_clr", 32'(flags));

    // Higher-priority arrival overrides while pending
    strobe_ei();
    pulse(9);
    push(32'h0028); push(9);
    tick();
    check("t4_vec9", 32'(vector)); check("t4_code9", 32'(irq_code));
    pulse(1);
    push(32'h0008); push(1);
    tick();
    check("t4_override_vec", 32'(vector)); check("t4_override_code", 32'(irq_code));
    push(32'h0008); push(0); push(0); push(32'h202);
    ack();
    check("t4_frozen_vec", 32'(vector)); check("t4_ack_req", 32'(irq_req));
    check("t4_ack_ie", 32'(ie)); check("t4_flags", 32'(flags));
    tick();
    push(1);
    skit(4'd9);
    check("t4_skit9_hit", 32'(skit_hit));
    push(1); push(0);
    skit(4'd1);
    check("t4_skit1_hit", 32'(skit_hit)); check("t4_clean", 32'(flags));

    // DI while pending drops REQ; EI+DI leaves IE clear
    strobe_ei();
    pulse(5);
    push(1); push(32'h0018);
    tick();
    check("t5_req", 32'(irq_req)); check("t5_vec", 32'(vector));
    push(0);
    di_stb = 1'b1; tick(); di_stb = 1'b0;
    check("t5_di_ie", 32'(ie));
    push(0); push(32'h020);
    tick();
    check("t5_req_drop", 32'(irq_req)); check("t5_flag_kept", 32'(flags));
    push(0);
    ei_stb = 1'b1; di_stb = 1'b1; tick(); ei_stb = 1'b0; di_stb = 1'b0;
    check("t5_ei_di", 32'(ie));
    skit(4'd5);

    // Async reset mid-handshake, then SKIT boundaries
    strobe_ei();
    pulse(2);
    push(1);
    tick();
    check("t6_req", 32'(irq_req));
    #2 rst_n = 1'b0;
    push(0); push(0); push(0); push(16'h0000);
    #1;
    check("t6_async_req", 32'(irq_req)); check("t6_async_flags", 32'(flags));
    check("t6_async_ie", 32'(ie));       check("t6_async_vec", 32'(vector));
    @(negedge clk);
    rst_n = 1'b1;
    pulse(6);
    push(1); push(32'h040);
    irq_pulse[6] = 1'b1; skit(4'd6); irq_pulse = '0;
    check("t6_same_cycle_hit", 32'(skit_hit)); check("t6_set_wins", 32'(flags));
    push(0); push(32'h040);
    skit(4'd12);
    check("t6_skit12_hit", 32'(skit_hit)); check("t6_skit12_flags", 32'(flags));
    push(1); push(0);
    skit(4'd6);
    check("t6_skit6_hit", 32'(skit_hit)); check("t6_skit6_clr", 32'(flags));
    push(1);
    tick();
    check("t6_hit_holds", 32'(skit_hit));
    strobe_ei();
    push(1); push(0);
    ack();
    check("t6_idle_ack_ie", 32'(ie)); check("t6_idle_ack_req", 32'(irq_req));

    vectors++;
    assert (sb_q.size() == 0) else begin
      miscompares++;
      $error("FAIL sb_drain: observed %0d leftover entries, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ika87ad_irq_ctrl.md
Name: ika87ad_irq_ctrl

Overview:
- Interrupt priority controller for the IKA87AD core. Sits between the per-source interrupt flag/edge-detect logic and the CPU sequencer.
- Latches request pulses from 11 sources and applies the mask and IE gating. Selects the highest-priority pending source and hands its vector to the sequencer through a REQ/ACK handshake.
- Clears flags automatically on acceptance (single-source groups) or through SKIT tests (shared-vector groups).

Parameters:
- NSRC, 11, number of interrupt sources (fixed source map below; do not change).

Ports:
- i_EMUCLK  in  1  system clock; all state changes on rising edge.
- i_MRST_n  in  1  asynchronous active-low reset.
- i_IRQ_PULSE  in  11  one-cycle request pulses. Index map: 0 NMI, 1 INTT0, 2 INTT1, 3 INT1, 4 INT2, 5 INTE0, 6 INTE1, 7 INTEIN, 8 INTAD, 9 INTSR, 10 INTST.
- i_MASK  in  10  mask bits for sources 10..1; 1 = masked. Driven by the MKH/MKL registers.
- i_EI_STB  in  1  EI instruction strobe.
- i_DI_STB  in  1  DI instruction strobe.
- i_IRQ_ACK  in  1  sequencer accepts the presented interrupt.
- i_SKIT_STB  in  1  SKIT test strobe.
- i_SKIT_CODE  in  4  source index to test.
- o_IRQ_REQ  out  1  interrupt request to the sequencer.
- o_VECTOR  out  16  service vector address.
- o_IRQ_CODE  out  4  index of the presented source.
- o_SKIT_HIT  out  1  flag value returned by the SKIT test.
- o_IE  out  1  current interrupt-enable flag.
- o_FLAGS  out  11  raw flag register (debug and verification).

Behaviour:
- Reset (async, i_MRST_n=0): flags, IE and o_IRQ_REQ are 0; o_VECTOR=16'h0000; o_IRQ_CODE=0; o_SKIT_HIT=0; FSM goes to IDLE.
- Flags:
  - flag[i] is set on the edge where i_IRQ_PULSE[i]=1, regardless of mask or IE.
  - If a set and a clear hit the same flag in the same cycle, set wins.
- Eligibility:
  - NMI (0) is eligible when flag[0]=1; it ignores mask and IE.
  - Source i≥1 is eligible when flag[i]=1, i_MASK[i]=0 and IE=1.
- Priority: a lower index wins. Groups and vectors:
  - {0} 16'h0004
  - {1,2} 16'h0008
  - {3,4} 16'h0010
  - {5,6} 16'h0018
  - {7,8} 16'h0020
  - {9,10} 16'h0028
- Shared-vector groups:
  - A group is "multi" when both of its members are unmasked.
  - Auto-clear of the accepted flag happens only for NMI or a non-multi group.
  - For a multi group, flags stay set until cleared by SKIT.
- FSM states: IDLE, PEND, ACKD.
  - IDLE: any eligible source → PEND. o_IRQ_REQ, o_VECTOR and o_IRQ_CODE are registered at that edge.
  - Latency: pulse at edge N → flag at N → o_IRQ_REQ=1 after edge N+1.
  - PEND: o_IRQ_REQ=1. o_VECTOR/o_IRQ_CODE are re-evaluated every cycle, so a higher-priority arrival overrides.
  - PEND, no eligible source (mask set, DI, SKIT clear): → IDLE; o_IRQ_REQ=0 after that edge.
  - PEND with i_IRQ_ACK=1:
    - o_VECTOR/o_IRQ_CODE are frozen.
    - IE is cleared; this also applies to NMI.
    - Auto-clear is applied.
    - → ACKD with o_IRQ_REQ=0.
  - ACKD: one dead cycle → IDLE. Minimum spacing between ACKs is 3 cycles.
  - i_IRQ_ACK outside PEND: ignored.
- IE:
  - i_EI_STB sets IE and i_DI_STB clears it, both at the next edge.
  - EI and DI in the same cycle: DI wins.
  - ACK clears IE and wins over EI in the same cycle.
- SKIT:
  - On i_SKIT_STB, o_SKIT_HIT is registered as flag[code] and flag[code] is cleared.
  - code 0 or >10: o_SKIT_HIT=0, no flag changes.
  - o_SKIT_HIT holds until the next strobe.
  - If SKIT and i_IRQ_PULSE hit the same index in one cycle: HIT=old flag and the flag ends up set.
- Reset mid-handshake: everything clears immediately; a pending ACK is lost and the sequencer must restart.

Test Plan:
- Reset, IE=1, mask=0, pulse[3] → o_IRQ_REQ=1 two edges later, VECTOR=0x0010, CODE=3. ACK → flag[3] stays set (group multi). SKIT code 3 → HIT=1, flag[3]=0.
- i_MASK[4]=1, pulse[3], ACK → flag[3] auto-cleared, IE=0, REQ low for at least 1 cycle; a second pulse[3] raises no REQ until EI.
- IE=0: pulse[8] → no REQ, flag[8]=1. Then pulse[0] → REQ, VECTOR=0x0004. ACK → flag[0]=0, flag[8] remains.
- In PEND with VECTOR=0x0028 (source 9), pulse[1] arrives → next cycle VECTOR=0x0008, CODE=1. ACK freezes 0x0008.
- In PEND for source 5, assert DI → REQ=0 next edge, FSM in IDLE, flag[5] retained. EI and DI together → IE=0.
- Assert i_MRST_n=0 asynchronously while REQ=1 → REQ, flags and IE go to 0 before the next clock edge. SKIT code 12 → HIT=0.
